// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 set-2 scancode decoder.
//   PS2_EXT / PS2_BRK   : extended and break prefix bytes
//   PS2_SPECIAL         : keyboard protocol bytes that never form a key event
//   KEY_R / KEY_T / KEY_Y : keys that select the operating mode
//   mode_e              : operating-mode register encoding
//   state_e             : sequence-assembly FSM states
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned PS2_NUM_SPECIAL = 6;
  localparam logic [7:0] PS2_SPECIAL [PS2_NUM_SPECIAL] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  localparam logic [7:0] KEY_R = 8'h2D;
  localparam logic [7:0] KEY_T = 8'h2C;
  localparam logic [7:0] KEY_Y = 8'h35;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_RECORD = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_e;

  function automatic logic is_special(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < PS2_NUM_SPECIAL; i++) begin
      if (b == PS2_SPECIAL[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// ps2_timeout_ctr: inter-byte timeout counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : zero the count (takes priority over enable_i)
//   enable_i     : advance the count by one this cycle
//   expire_o     : count has reached TIMEOUT_CYC-1 and is still running
module ps2_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: assembles PS/2 set-2 byte sequences into key events.
//   clk, rst         : system clock, synchronous active-high reset
//   rx_data/rx_valid : received scancode byte and its strobe
//   rx_err           : receiver error strobe, abandons any partial sequence
//   ev_code/ev_ext/ev_break/ev_valid/ev_ready : event output register
//   mode             : 0 manual, 1 auto, 2 record
//   overflow         : sticky flag, set when an event is dropped
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 2_500_000,
  parameter bit          FILTER_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] mode,
  output logic       overflow
);

  state_e     state_q, state_d;
  logic [8:0] last_make_q, last_make_d;
  logic       last_valid_q, last_valid_d;
  mode_e      mode_q, mode_d;
  logic [7:0] ev_code_q, ev_code_d;
  logic       ev_ext_q, ev_ext_d;
  logic       ev_break_q, ev_break_d;
  logic       ev_valid_q, ev_valid_d;
  logic       overflow_q, overflow_d;

  logic       expire;
  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  logic [8:0] key_id;
  logic       suppress;
  logic       accept;

  ps2_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (rx_valid || (state_q == ST_IDLE)),
    .enable_i(state_q != ST_IDLE),
    .expire_o(expire)
  );

  // Sequence assembly: error beats a byte, a byte beats the timeout.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      if (is_special(rx_data)) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (rx_data == PS2_EXT)      state_d = ST_E0;
            else if (rx_data == PS2_BRK) state_d = ST_F0;
            else                         emit    = 1'b1;
          end
          ST_E0: begin
            if (rx_data == PS2_BRK) begin
              state_d = ST_E0F0;
            end else begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          ST_F0, ST_E0F0: begin
            if (rx_data == PS2_EXT) begin
              state_d = ST_E0;
            end else if (rx_data != PS2_BRK) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
              emit_ext = (state_q == ST_E0F0);
              state_d  = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (expire) begin
      state_d = ST_IDLE;
    end
  end

  // Repeat filter, mode register and output register.
  always_comb begin
    key_id   = {emit_ext, rx_data};
    suppress = FILTER_REPEAT && emit && !emit_brk &&
               last_valid_q && (key_id == last_make_q);
    accept   = emit && !suppress;

    last_make_d  = last_make_q;
    last_valid_d = last_valid_q;
    mode_d       = mode_q;
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_break_d   = ev_break_q;
    ev_valid_d   = ev_valid_q;
    overflow_d   = overflow_q;

    if (accept && !emit_brk) begin
      last_make_d  = key_id;
      last_valid_d = 1'b1;
    end
    if (emit && emit_brk && (key_id == last_make_q)) begin
      last_valid_d = 1'b0;
    end

    // Mode follows the key even when the event itself is dropped below.
    if (accept && !emit_brk && !emit_ext) begin
      if (rx_data == KEY_R)      mode_d = MODE_AUTO;
      else if (rx_data == KEY_T) mode_d = MODE_RECORD;
      else if (rx_data == KEY_Y) mode_d = MODE_MANUAL;
    end

    if (accept) begin
      if (!ev_valid_q || ev_ready) begin
        ev_code_d  = rx_data;
        ev_ext_d   = emit_ext;
        ev_break_d = emit_brk;
        ev_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_make_q  <= '0;
      last_valid_q <= 1'b0;
      mode_q       <= MODE_MANUAL;
      ev_code_q    <= '0;
      ev_ext_q     <= 1'b0;
      ev_break_q   <= 1'b0;
      ev_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_make_q  <= last_make_d;
      last_valid_q <= last_valid_d;
      mode_q       <= mode_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_break_q   <= ev_break_d;
      ev_valid_q   <= ev_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ev_code  = ev_code_q;
  assign ev_ext   = ev_ext_q;
  assign ev_break = ev_break_q;
  assign ev_valid = ev_valid_q;
  assign mode     = mode_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] mode;
  logic       overflow;

  ps2_scan_decoder #(
    .TIMEOUT_CYC  (T),
    .FILTER_REPEAT(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .ev_code (ev_code),
    .ev_ext  (ev_ext),
    .ev_break(ev_break),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .mode    (mode),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected events, packed {ext, brk, code}.
  logic [9:0] sb_q[$];

  // Reference model: pending prefixes, held key, mode.
  bit       m_ext, m_brk;
  int       last_cyc;
  bit [8:0] m_last;
  bit       m_last_v;
  int       m_mode;
  bit       rand_ready;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic bit special(input bit [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_last = '0; m_last_v = 0; m_mode = 0;
    last_cyc = 0;
    sb_q.delete();
  endtask

  task automatic model_byte(input bit [7:0] b, input bit valid, input bit err,
                            input bit drop, input int at);
    bit [8:0] id;
    if (err) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    if (!valid) return;
    if ((m_ext || m_brk) && (at - last_cyc > T)) begin
      m_ext = 0; m_brk = 0;
    end
    last_cyc = at;
    if (special(b)) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !(m_ext && !m_brk)) begin
      m_ext = 1; m_brk = 0;
    end else begin
      id = {m_ext, b};
      if (m_brk) begin
        if (id == m_last) m_last_v = 0;
        if (!drop) sb_q.push_back({m_ext, 1'b1, b});
      end else if (!(m_last_v && id == m_last)) begin
        m_last = id; m_last_v = 1;
        if (!m_ext) begin
          if (b == 8'h2D) m_mode = 1;
          else if (b == 8'h2C) m_mode = 2;
          else if (b == 8'h35) m_mode = 0;
        end
        if (!drop) sb_q.push_back({m_ext, 1'b0, b});
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input bit [7:0] b, input bit valid = 1, input bit err = 0,
                      input bit drop = 0);
    rx_data = b; rx_valid = valid; rx_err = err;
    tick();
    rx_valid = 0; rx_err = 0;
    model_byte(b, valid, err, drop, cyc);
    check("mode", int'(mode), m_mode);
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event actual=%0h expected=none",
                 {ev_ext, ev_break, ev_code});
      end else begin
        check("event", int'({ev_ext, ev_break, ev_code}), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(ev_valid), 0);
    check({tag, "_code"}, int'(ev_code), 0);
    check({tag, "_ext"}, int'(ev_ext), 0);
    check({tag, "_break"}, int'(ev_break), 0);
    check({tag, "_mode"}, int'(mode), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  logic [7:0] pool [16];

  initial begin
    int waited, extra, r;
    bit [7:0] b;
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h32, 8'h75,
             8'h2D, 8'h2C, 8'h35, 8'hAA, 8'hFA, 8'h00, 8'h4B, 8'h00};
    rst = 1; rx_data = '0; rx_valid = 0; rx_err = 0; ev_ready = 0;
    rand_ready = 0;
    model_reset();
    tick(); tick();
    check_reset_outputs("reset");
    rst = 0;
    ev_ready = 1;
    tick();

    // Make then break of 1C, each valid for exactly one cycle.
    send(8'h1C);
    check("lat_make", int'(ev_valid), 1);
    tick();
    check("pulse_make", int'(ev_valid), 0);
    send(8'hF0);
    check("no_ev_prefix", int'(ev_valid), 0);
    send(8'h1C);
    check("lat_break", int'(ev_valid), 1);
    check("break_flag", int'(ev_break), 1);
    tick();
    check("pulse_break", int'(ev_valid), 0);

    // Extended make/break.
    send(8'hE0); send(8'h75);
    check("ext_make", int'(ev_ext), 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break", int'({ev_ext, ev_break}), 3);
    check("mode_ext", int'(mode), 0);

    // Mode keys and repeat filter.
    send(8'h2D);
    check("mode_auto", int'(mode), 1);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h2C);
    check("mode_record", int'(mode), 2);
    send(8'hF0); send(8'h35);
    check("mode_brk_keep", int'(mode), 2);
    send(8'h35);
    check("mode_manual", int'(mode), 0);
    tick();

    // Overflow: held event survives, second is dropped.
    ev_ready = 0;
    send(8'h1C);
    send(8'h32, 1, 0, 1);
    check("ovf_code", int'(ev_code), 8'h1C);
    check("ovf_valid", int'(ev_valid), 1);
    check("ovf_flag", int'(overflow), 1);
    ev_ready = 1;
    tick();
    check("ovf_drain", int'(ev_valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Timeout abandons a pending break prefix.
    send(8'hF0);
    repeat (T) tick();
    send(8'h1C);
    check("timeout_make", int'(ev_break), 0);
    check("timeout_valid", int'(ev_valid), 1);
    send(8'hF0); send(8'h1C);
    // Receiver error abandons an E0 prefix.
    send(8'hE0);
    send(8'h00, 0, 1);
    send(8'h1C);
    check("err_ext", int'(ev_ext), 0);
    check("err_valid", int'(ev_valid), 1);
    tick();

    // Reset in E0F0 with an event pending.
    ev_ready = 0;
    send(8'h4B); send(8'hE0); send(8'hF0);
    rst = 1;
    tick();
    check_reset_outputs("midrst");
    rst = 0;
    model_reset();
    ev_ready = 1;
    send(8'h1C);
    check("post_rst_valid", int'(ev_valid), 1);
    check("post_rst_make", int'({ev_ext, ev_break, ev_code}), 8'h1C);
    tick();

    // Randomized traffic; bytes issued only once the output slot is empty.
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      waited = 0;
      while (ev_valid && waited < 100) begin
        tick();
        waited++;
      end
      if (ev_valid) begin
        check("slot_drain_timeout", int'(ev_valid), 0);
        break;
      end
      r = $urandom_range(0, 19);
      extra = (r == 0) ? T + 5 : $urandom_range(0, 3);
      repeat (extra) tick();
      // Keep byte gaps clear of the timeout boundary.
      while ((cyc + 1 - last_cyc) >= T - 2 && (cyc + 1 - last_cyc) <= T + 2) tick();
      if (ev_valid) begin
        n--;
        continue;
      end
      b = pool[$urandom_range(0, 15)];
      if (b == 8'h00 && $urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 39);
      if (r == 0)      send(b, 1, 1);
      else if (r == 1) send(b, 0, 1);
      else             send(b);
    end

    rand_ready = 0;
    ev_ready = 1;
    repeat (4) tick();
    check("sb_empty", sb_q.size(), 0);
    check("final_overflow", int'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
